// File: rtl/apes_top_core_if.sv
// Telemetry serial ports (counter and housekeeping) shared by the rocket encoder and the APES core.
interface apes_top_core_if;
    logic Cnt_Gtclk;
    logic Cnt_Invload;
    logic Cnt_Data;
    logic Hk_Gtclk;
    logic Hk_Invload;
    logic Hk_Data;

    modport master (
        output Cnt_Gtclk, Cnt_Invload, Hk_Gtclk, Hk_Invload,
        input  Cnt_Data, Hk_Data
    );

    modport slave (
        input  Cnt_Gtclk, Cnt_Invload, Hk_Gtclk, Hk_Invload,
        output Cnt_Data, Hk_Data
    );
endinterface

// File: rtl/apes_top_core.sv
// APES instrument core: 50 pulse counters serialised on the Cnt port, ADC128S102 housekeeping scan
// served on the Hk port, and conditioning of the SAFE/STIM/RESET/HVEN ground commands.
module apes_top_core #(
    localparam int unsigned NCH   = 50,
    localparam int unsigned WBITS = 10
) (
    input  logic             Ext_clk_50mhz,
    input  logic             Gse_reset,
    input  logic [NCH-1:0]   Inpulse,
    input  logic             Safe_cmd,
    input  logic             Stim_cmd_n,
    input  logic             Reset_cmd_n,
    input  logic             Hven_cmd_n,
    apes_top_core_if.slave   tlm,
    output logic             Adc_clk,
    output logic             Adc_sdi,
    output logic             Adc_cs1,
    output logic             Adc_cs2,
    input  logic             Adc_sdo,
    output logic             Mcp_dac_clk,
    output logic             Mcp_dac_sdi,
    output logic             Mcp_dac_cs,
    output logic             Dac1_sck,
    output logic             Dac1_sdi,
    output logic             Dac1_sync_n,
    output logic             Hven,
    output logic             Sync
);
    localparam int unsigned NWORDS      = 52;
    localparam int unsigned HK_WORDS    = 17;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned HK_IDX_W    = 5;
    localparam int unsigned FC_W        = 7;
    localparam int unsigned ADC_DIV     = 8;
    localparam int unsigned DIV_W       = 3;
    localparam int unsigned HALF_W      = 5;
    localparam int unsigned GAP_HALVES  = 4;
    localparam int unsigned XFER_HALVES = 32;
    localparam int unsigned RES_W       = 12;
    localparam int unsigned NRES        = 16;
    localparam logic [WBITS-1:0] HDR      = 10'h2AA;
    // {sdo, safe, stim_n, hven_n, rst_n, cnt_gt, cnt_inv, hk_gt, hk_inv} at rest
    localparam logic [8:0]       CTL_IDLE = 9'h075;

    typedef enum logic {S_GAP, S_XFER} adc_state_e;

    logic [NCH-1:0]      pls_s1, pls_s2, pls_d, pls_rise;
    logic [8:0]          ctl_s1, ctl_s2;
    logic [4:0]          edg_d;
    logic                hk_inv_s, hk_gt_s, cnt_inv_s, cnt_gt_s, rst_n_s, hven_n_s, stim_n_s, safe_s, sdo_s;
    logic                soft_rst, clr;
    logic                cnt_load, cnt_shift, hk_load, hk_shift, frame_start;
    logic [WBITS-1:0]    cnt  [NCH];
    logic [WBITS-1:0]    snap [NCH];
    logic [WBITS-1:0]    cnt_sh, hk_sh, cnt_word, hk_word;
    logic [IDX_W-1:0]    cnt_idx;
    logic [HK_IDX_W-1:0] hk_idx;
    logic [FC_W-1:0]     frame_cnt;
    logic [2:0]          hv_cnt;
    adc_state_e          adc_state, adc_state_d;
    logic                adc_tick, adc_start, adc_done;
    logic [DIV_W-1:0]    adc_div;
    logic [HALF_W-1:0]   adc_half;
    logic [3:0]          adc_slot;
    logic [14:0]         adc_tx;
    logic [RES_W-1:0]    adc_rx;
    logic [RES_W-1:0]    res [NRES];
    logic                adc_lsb_unused;

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge Ext_clk_50mhz) begin
        if (Gse_reset) begin
            pls_s1 <= '0;
            pls_s2 <= '0;
            pls_d  <= '0;
            ctl_s1 <= CTL_IDLE;
            ctl_s2 <= CTL_IDLE;
            edg_d  <= CTL_IDLE[4:0];
        end else begin
            pls_s1 <= Inpulse;
            pls_s2 <= pls_s1;
            pls_d  <= pls_s2;
            ctl_s1 <= {Adc_sdo, Safe_cmd, Stim_cmd_n, Hven_cmd_n, Reset_cmd_n,
                       tlm.Cnt_Gtclk, tlm.Cnt_Invload, tlm.Hk_Gtclk, tlm.Hk_Invload};
            ctl_s2 <= ctl_s1;
            edg_d  <= ctl_s2[4:0];
        end
    end

    assign {sdo_s, safe_s, stim_n_s, hven_n_s, rst_n_s, cnt_gt_s, cnt_inv_s, hk_gt_s, hk_inv_s} = ctl_s2;
    assign pls_rise    = pls_s2 & ~pls_d;
    assign soft_rst    = ~rst_n_s & ~edg_d[4];
    assign clr         = Gse_reset | soft_rst;
    assign cnt_load    = edg_d[2] & ~cnt_inv_s;
    assign cnt_shift   = edg_d[3] & ~cnt_gt_s;
    assign hk_load     = edg_d[0] & ~hk_inv_s;
    assign hk_shift    = edg_d[1] & ~hk_gt_s;
    assign frame_start = cnt_load & (cnt_idx == '0);

    // Live counters; a pulse edge landing on the frame clear starts the new interval at 1
    always_ff @(posedge Ext_clk_50mhz) begin
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (frame_start) begin
                    snap[i] <= stim_n_s ? cnt[i] : WBITS'(i + 1);
                    cnt[i]  <= WBITS'(pls_rise[i]);
                end else if (pls_rise[i] && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + WBITS'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_word = HDR;
        if (cnt_idx == IDX_W'(NWORDS - 1))
            cnt_word = {Hven, safe_s, ~stim_n_s, frame_cnt};
        else if (cnt_idx != '0)
            cnt_word = snap[cnt_idx - IDX_W'(1)];
        hk_word = HDR;
        if (hk_idx != '0)
            hk_word = res[hk_idx[3:0] - 4'd1][RES_W-1:2];
        adc_lsb_unused = 1'b0;
        for (int k = 0; k < NRES; k++)
            adc_lsb_unused = adc_lsb_unused ^ (^res[k][1:0]);
    end

    // Telemetry shift registers, MSB first
    always_ff @(posedge Ext_clk_50mhz) begin
        if (clr) begin
            cnt_sh    <= '0;
            cnt_idx   <= '0;
            frame_cnt <= '0;
            Sync      <= 1'b0;
            hk_sh     <= '0;
            hk_idx    <= '0;
        end else begin
            Sync <= frame_start;
            if (cnt_load) begin
                cnt_sh <= cnt_word;
                if (cnt_idx == IDX_W'(NWORDS - 1)) begin
                    cnt_idx   <= '0;
                    frame_cnt <= frame_cnt + FC_W'(1);
                end else begin
                    cnt_idx <= cnt_idx + IDX_W'(1);
                end
            end else if (cnt_shift) begin
                cnt_sh <= {cnt_sh[WBITS-2:0], 1'b0};
            end
            if (hk_load) begin
                hk_sh  <= hk_word;
                hk_idx <= (hk_idx == HK_IDX_W'(HK_WORDS - 1)) ? '0 : hk_idx + HK_IDX_W'(1);
            end else if (hk_shift) begin
                hk_sh <= {hk_sh[WBITS-2:0], 1'b0};
            end
        end
    end

    assign tlm.Cnt_Data = cnt_sh[WBITS-1];
    assign tlm.Hk_Data  = hk_sh[WBITS-1];

    // HV enable needs four consecutive low cycles of the command; soft reset leaves it alone
    always_ff @(posedge Ext_clk_50mhz) begin
        if (Gse_reset) begin
            hv_cnt <= '0;
            Hven   <= 1'b0;
        end else begin
            if (hven_n_s)
                hv_cnt <= '0;
            else if (hv_cnt != 3'd4)
                hv_cnt <= hv_cnt + 3'd1;
            Hven <= ~hven_n_s & (hv_cnt >= 3'd3) & ~safe_s;
        end
    end

    assign adc_tick = (adc_div == DIV_W'(ADC_DIV - 1));

    always_ff @(posedge Ext_clk_50mhz) begin
        if (clr) adc_state <= S_GAP;
        else     adc_state <= adc_state_d;
    end

    always_comb begin
        adc_state_d = adc_state;
        adc_start   = 1'b0;
        adc_done    = 1'b0;
        if (adc_tick) begin
            case (adc_state)
                S_GAP: if (adc_half == HALF_W'(GAP_HALVES - 1)) begin
                    adc_state_d = S_XFER;
                    adc_start   = 1'b1;
                end
                S_XFER: if (adc_half == HALF_W'(XFER_HALVES - 1)) begin
                    adc_state_d = S_GAP;
                    adc_done    = 1'b1;
                end
                default: adc_state_d = S_GAP;
            endcase
        end
    end

    // Each ADC returns the conversion of the address it was sent in its previous frame
    always_ff @(posedge Ext_clk_50mhz) begin
        if (clr) begin
            adc_div  <= '0;
            adc_half <= '0;
            adc_slot <= '0;
            adc_tx   <= '0;
            adc_rx   <= '0;
            Adc_clk  <= 1'b0;
            Adc_sdi  <= 1'b0;
            Adc_cs1  <= 1'b1;
            Adc_cs2  <= 1'b1;
            for (int k = 0; k < NRES; k++) res[k] <= '0;
        end else begin
            adc_div <= adc_div + DIV_W'(1);
            if (adc_tick) begin
                adc_half <= adc_half + HALF_W'(1);
                if (adc_start) begin
                    adc_half <= '0;
                    Adc_cs1  <= adc_slot[3];
                    Adc_cs2  <= ~adc_slot[3];
                    Adc_sdi  <= 1'b0;
                    adc_tx   <= {1'b0, adc_slot[2:0], 11'd0};
                end else if (adc_done) begin
                    adc_half <= '0;
                    Adc_clk  <= 1'b0;
                    Adc_sdi  <= 1'b0;
                    Adc_cs1  <= 1'b1;
                    Adc_cs2  <= 1'b1;
                    res[{adc_slot[3], adc_slot[2:0] - 3'd1}] <= adc_rx;
                    adc_slot <= adc_slot + 4'd1;
                end else if (adc_state == S_XFER) begin
                    if (!Adc_clk) begin
                        Adc_clk <= 1'b1;
                        adc_rx  <= {adc_rx[RES_W-2:0], sdo_s};
                    end else begin
                        Adc_clk <= 1'b0;
                        Adc_sdi <= adc_tx[14];
                        adc_tx  <= {adc_tx[13:0], 1'b0};
                    end
                end
            end
        end
    end

    assign Mcp_dac_clk = 1'b0;
    assign Mcp_dac_sdi = 1'b0;
    assign Mcp_dac_cs  = 1'b1;
    assign Dac1_sck    = 1'b0;
    assign Dac1_sdi    = 1'b0;
    assign Dac1_sync_n = 1'b1;
endmodule

// File: tb/tb_apes_top_core.sv
// Directed bench for apes_top_core: reset state, counter frames, STIM, HV enable, soft reset, ADC housekeeping.
module tb_apes_top_core;
    logic        Ext_clk_50mhz = 1'b0;
    logic        Gse_reset;
    logic [49:0] Inpulse;
    logic        Safe_cmd, Stim_cmd_n, Reset_cmd_n, Hven_cmd_n;
    logic        Adc_clk, Adc_sdi, Adc_cs1, Adc_cs2;
    logic        Adc_sdo = 1'b0;
    logic        Mcp_dac_clk, Mcp_dac_sdi, Mcp_dac_cs, Dac1_sck, Dac1_sdi, Dac1_sync_n;
    logic        Hven, Sync;
    int          n_cmp = 0;
    int          n_err = 0;
    int          sync_cnt = 0;
    logic [9:0]  fw [52];
    logic [9:0]  w;
    logic [15:0] adc_word = 16'h0;
    int          adc_bit = 16;
    logic        sclk_q = 1'b0;

    apes_top_core_if tlm ();

    apes_top_core dut (
        .Ext_clk_50mhz (Ext_clk_50mhz),
        .Gse_reset     (Gse_reset),
        .Inpulse       (Inpulse),
        .Safe_cmd      (Safe_cmd),
        .Stim_cmd_n    (Stim_cmd_n),
        .Reset_cmd_n   (Reset_cmd_n),
        .Hven_cmd_n    (Hven_cmd_n),
        .tlm           (tlm),
        .Adc_clk       (Adc_clk),
        .Adc_sdi       (Adc_sdi),
        .Adc_cs1       (Adc_cs1),
        .Adc_cs2       (Adc_cs2),
        .Adc_sdo       (Adc_sdo),
        .Mcp_dac_clk   (Mcp_dac_clk),
        .Mcp_dac_sdi   (Mcp_dac_sdi),
        .Mcp_dac_cs    (Mcp_dac_cs),
        .Dac1_sck      (Dac1_sck),
        .Dac1_sdi      (Dac1_sdi),
        .Dac1_sync_n   (Dac1_sync_n),
        .Hven          (Hven),
        .Sync          (Sync)
    );

    always #10 Ext_clk_50mhz = ~Ext_clk_50mhz;

    always @(negedge Ext_clk_50mhz) if (Sync === 1'b1) sync_cnt++;

    // ADC pair model: ADC1 always converts 0x011, ADC2 0x055; DOUT moves on SCLK falling
    always @(negedge Ext_clk_50mhz) begin
        if (Adc_cs1 !== 1'b0 && Adc_cs2 !== 1'b0) begin
            adc_bit = 16;
        end else begin
            if (adc_bit == 16) begin
                adc_word = (Adc_cs1 === 1'b0) ? 16'h0011 : 16'h0055;
                adc_bit  = 15;
            end else if (Adc_clk === 1'b0 && sclk_q === 1'b1 && adc_bit > 0) begin
                adc_bit = adc_bit - 1;
            end
            Adc_sdo = adc_word[adc_bit[3:0]];
        end
        sclk_q = Adc_clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Ext_clk_50mhz);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_word(input bit hk, output logic [9:0] word);
        if (hk) tlm.Hk_Invload = 1'b0; else tlm.Cnt_Invload = 1'b0;
        cyc(3);
        if (hk) tlm.Hk_Invload = 1'b1; else tlm.Cnt_Invload = 1'b1;
        cyc(3);
        for (int b = 9; b >= 0; b--) begin
            word[b] = hk ? tlm.Hk_Data : tlm.Cnt_Data;
            if (hk) tlm.Hk_Gtclk = 1'b1; else tlm.Cnt_Gtclk = 1'b1;
            cyc(3);
            if (hk) tlm.Hk_Gtclk = 1'b0; else tlm.Cnt_Gtclk = 1'b0;
            cyc(3);
        end
    endtask

    task automatic rd_cnt_frame();
        for (int k = 0; k < 52; k++) rd_word(1'b0, fw[k]);
    endtask

    task automatic pulse(input int ch, input int n);
        repeat (n) begin
            Inpulse[ch] = 1'b1;
            cyc(2);
            Inpulse[ch] = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        Gse_reset = 1'b1;
        Inpulse = '0;
        Safe_cmd = 1'b0;
        Stim_cmd_n = 1'b1;
        Reset_cmd_n = 1'b1;
        Hven_cmd_n = 1'b1;
        tlm.Cnt_Gtclk = 1'b0;
        tlm.Cnt_Invload = 1'b1;
        tlm.Hk_Gtclk = 1'b0;
        tlm.Hk_Invload = 1'b1;
        cyc(5);
        Gse_reset = 1'b0;
        cyc(1);

        chk("rst_hven", 32'(Hven), 32'h0);
        chk("rst_sync", 32'(Sync), 32'h0);
        chk("rst_cs1", 32'(Adc_cs1), 32'h1);
        chk("rst_cs2", 32'(Adc_cs2), 32'h1);
        chk("rst_adc_clk", 32'(Adc_clk), 32'h0);
        chk("rst_adc_sdi", 32'(Adc_sdi), 32'h0);
        chk("rst_cnt_data", 32'(tlm.Cnt_Data), 32'h0);
        chk("rst_hk_data", 32'(tlm.Hk_Data), 32'h0);
        chk("dac_mcp_cs", 32'(Mcp_dac_cs), 32'h1);
        chk("dac_mcp_clk_sdi", 32'({Mcp_dac_clk, Mcp_dac_sdi}), 32'h0);
        chk("dac1_sync_n", 32'(Dac1_sync_n), 32'h1);
        chk("dac1_sck_sdi", 32'({Dac1_sck, Dac1_sdi}), 32'h0);

        // Frame A: no pulses since reset
        rd_cnt_frame();
        chk("frmA_hdr", 32'(fw[0]), 32'h2AA);
        for (int k = 1; k <= 50; k++) chk($sformatf("frmA_w%0d", k), 32'(fw[k]), 32'h0);
        chk("frmA_status", 32'(fw[51]), 32'h000);
        chk("frmA_sync_once", 32'(sync_cnt), 32'd1);

        // Frame B: 3 pulses on ch0, saturation on ch49
        pulse(0, 3);
        pulse(49, 1025);
        rd_cnt_frame();
        chk("frmB_hdr", 32'(fw[0]), 32'h2AA);
        chk("frmB_ch0", 32'(fw[1]), 32'd3);
        chk("frmB_ch1", 32'(fw[2]), 32'd0);
        chk("frmB_ch48", 32'(fw[49]), 32'd0);
        chk("frmB_ch49_sat", 32'(fw[50]), 32'd1023);
        chk("frmB_status", 32'(fw[51]), 32'h001);
        chk("frmB_sync", 32'(sync_cnt), 32'd2);

        // STIM: two frames, second checked
        Stim_cmd_n = 1'b0;
        cyc(4);
        rd_cnt_frame();
        rd_cnt_frame();
        for (int k = 1; k <= 50; k++) chk($sformatf("stim_w%0d", k), 32'(fw[k]), 32'(k));
        chk("stim_status", 32'(fw[51]), 32'h083);
        chk("stim_bit7", 32'(fw[51][7]), 32'h1);
        Stim_cmd_n = 1'b1;
        cyc(4);

        // HV enable after 4 synced low cycles, SAFE override
        Hven_cmd_n = 1'b0;
        cyc(5);
        chk("hven_not_yet", 32'(Hven), 32'h0);
        cyc(1);
        chk("hven_on", 32'(Hven), 32'h1);
        Safe_cmd = 1'b1;
        cyc(3);
        chk("hven_safe_off", 32'(Hven), 32'h0);
        Safe_cmd = 1'b0;
        cyc(3);
        chk("hven_safe_release", 32'(Hven), 32'h1);

        // Soft reset: a 1-cycle glitch is ignored, a 4-cycle low restarts the frame
        rd_word(1'b0, w);
        chk("soft_pre_hdr", 32'(w), 32'h2AA);
        rd_word(1'b0, w);
        chk("soft_pre_w1", 32'(w), 32'h0);
        Reset_cmd_n = 1'b0;
        cyc(1);
        Reset_cmd_n = 1'b1;
        cyc(4);
        rd_word(1'b0, w);
        chk("soft_glitch_w2", 32'(w), 32'h0);
        Reset_cmd_n = 1'b0;
        cyc(4);
        Reset_cmd_n = 1'b1;
        cyc(4);
        chk("soft_hven_kept", 32'(Hven), 32'h1);
        rd_cnt_frame();
        chk("soft_hdr", 32'(fw[0]), 32'h2AA);
        chk("soft_status", 32'(fw[51]), 32'h200);
        chk("soft_sync", 32'(sync_cnt), 32'd6);
        Hven_cmd_n = 1'b1;
        cyc(3);
        chk("hven_cmd_off", 32'(Hven), 32'h0);

        // Housekeeping after more than two full ADC scans
        cyc(10000);
        rd_word(1'b1, w);
        chk("hk_hdr", 32'(w), 32'h2AA);
        for (int k = 1; k <= 16; k++) begin
            rd_word(1'b1, w);
            chk($sformatf("hk_w%0d", k), 32'(w), (k <= 8) ? 32'h004 : 32'h015);
        end
        rd_word(1'b1, w);
        chk("hk_wrap_hdr", 32'(w), 32'h2AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: observed no completion, required completion within 200000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
